// File: rtl/purge_health_monitor.sv
// Health monitor for the N-module self-purging adder: survivor count, health class, purge-event log.
// Optional build macro PURGE_MON_TIMESTAMP_EN adds a 16-bit free-running timestamp to each logged event.
module purge_health_monitor #(
    parameter int N         = 6,
    parameter int THR       = 4,
    parameter int LOG_DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N-1:0]             active_i,
    input  logic                     sum_i,
    input  logic                     rearm_req,
    input  logic                     event_pop,
    output logic                     rearm_j,
    output logic [$clog2(N+1)-1:0]   active_cnt,
    output logic [1:0]               health,
    output logic                     event_valid,
    output logic [$clog2(N)-1:0]     event_idx,
    output logic [15:0]              event_time,
    output logic                     overflow,
    output logic                     glitch
);

    localparam int CW = $clog2(N+1);
    localparam int IW = $clog2(N);
    localparam int AW = $clog2(LOG_DEPTH);
    localparam logic [CW-1:0] N_C   = CW'(N);
    localparam logic [CW-1:0] THR_C = CW'(THR);

    // state    | meaning
    // IDLE     | first cycle after reset release
    // ARM      | one-cycle J pulse to re-enable every module, pending mask cleared
    // SETTLE   | two cycles for the adder flops to reload; edges ignored
    // HEALTHY  | all N modules active
    // DEGRADED | THR..N-1 active, majority still guaranteed
    // FAILED   | fewer than THR active
    typedef enum logic [2:0] {IDLE, ARM, SETTLE, HEALTHY, DEGRADED, FAILED} state_t;

    state_t          state, state_next;
    logic            settle_cnt;
    logic [N-1:0]    act_q;
    logic [N-1:0]    pending, pending_next;
    logic [N-1:0]    fall, rise, push_sel;
    logic [IW-1:0]   push_idx;
    logic            push_req, monitoring;
    logic [CW-1:0]   cnt_now;
    logic [AW:0]     wr_ptr, rd_ptr;
    logic            full, empty, do_push, do_pop;
    logic [IW-1:0]   mem_idx [LOG_DEPTH];

    // sum_i is carried on the port for a future stuck-output check; nothing consumes it yet.
    logic unused_sum;
    assign unused_sum = sum_i;

    function automatic logic [CW-1:0] popcount(input logic [N-1:0] v);
        logic [CW-1:0] c;
        c = '0;
        for (int i = 0; i < N; i++) c = c + CW'(v[i]);
        return c;
    endfunction

    // Classification uses the count of act_q directly (the value active_cnt takes next edge),
    // so a full reload seen one cycle after the J pulse is classified at the end of SETTLE.
    assign cnt_now    = popcount(act_q);
    assign monitoring = (state == HEALTHY) || (state == DEGRADED) || (state == FAILED);
    assign fall       = act_q & ~active_i;
    assign rise       = ~act_q & active_i;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     state_next = ARM;
            ARM:      state_next = SETTLE;
            SETTLE: begin
                if (settle_cnt) begin
                    if (cnt_now == N_C)       state_next = HEALTHY;
                    else if (cnt_now >= THR_C) state_next = DEGRADED;
                    else                       state_next = FAILED;
                end
            end
            HEALTHY: begin
                if (rearm_req)             state_next = ARM;
                else if (cnt_now < THR_C)  state_next = FAILED;
                else if (cnt_now < N_C)    state_next = DEGRADED;
            end
            DEGRADED: begin
                if (rearm_req)             state_next = ARM;
                else if (cnt_now < THR_C)  state_next = FAILED;
            end
            FAILED: begin
                if (rearm_req)             state_next = ARM;
            end
            default:  state_next = IDLE;
        endcase
    end

    always_comb begin
        health = 2'd0;
        case (state)
            HEALTHY:  health = 2'd1;
            DEGRADED: health = 2'd2;
            FAILED:   health = 2'd3;
            default:  health = 2'd0;
        endcase
    end

    assign rearm_j = (state == ARM);

    always_comb begin
        push_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (pending[i]) push_idx = IW'(i);
        end
    end

    assign push_sel = pending & (~pending + N'(1));
    assign push_req = |pending;
    assign pending_next = (state == ARM) ? '0
                        : ((pending & ~push_sel) | (monitoring ? fall : '0));

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = event_pop && !empty;
    assign do_push = push_req && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            settle_cnt <= 1'b0;
            act_q      <= '0;
            active_cnt <= '0;
            pending    <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            overflow   <= 1'b0;
            glitch     <= 1'b0;
            for (int i = 0; i < LOG_DEPTH; i++) mem_idx[i] <= '0;
        end else begin
            state      <= state_next;
            settle_cnt <= (state == SETTLE) ? ~settle_cnt : 1'b0;
            act_q      <= active_i;
            active_cnt <= cnt_now;
            pending    <= pending_next;
            if (do_push) begin
                mem_idx[wr_ptr[AW-1:0]] <= push_idx;
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + (AW+1)'(1);
            if (push_req && full && !do_pop) overflow <= 1'b1;
            if (monitoring && (|rise)) glitch <= 1'b1;
        end
    end

    assign event_valid = !empty;
    assign event_idx   = mem_idx[rd_ptr[AW-1:0]];

`ifdef PURGE_MON_TIMESTAMP_EN
    logic [15:0] ts;
    logic [15:0] mem_time [LOG_DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts <= '0;
            for (int i = 0; i < LOG_DEPTH; i++) mem_time[i] <= '0;
        end else begin
            ts <= ts + 16'd1;
            if (do_push) mem_time[wr_ptr[AW-1:0]] <= ts;
        end
    end

    assign event_time = mem_time[rd_ptr[AW-1:0]];
`else
    assign event_time = '0;
`endif

endmodule

// File: tb/tb_purge_health_monitor.sv
// Directed bench for purge_health_monitor: vector table for the main flow, hand sequences for FIFO/glitch/reset corners.
module tb_purge_health_monitor;

    logic        clk;
    logic        rst_n;
    logic [5:0]  active_i;
    logic        sum_i;
    logic        rearm_req;
    logic        event_pop;
    logic        rearm_j;
    logic [2:0]  active_cnt;
    logic [1:0]  health;
    logic        event_valid;
    logic [2:0]  event_idx;
    logic [15:0] event_time;
    logic        overflow;
    logic        glitch;

    int checks = 0;
    int failures = 0;

`ifdef PURGE_MON_TIMESTAMP_EN
    localparam bit TS_ON = 1'b1;
`else
    localparam bit TS_ON = 1'b0;
`endif

    purge_health_monitor #(.N(6), .THR(4), .LOG_DEPTH(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .active_i    (active_i),
        .sum_i       (sum_i),
        .rearm_req   (rearm_req),
        .event_pop   (event_pop),
        .rearm_j     (rearm_j),
        .active_cnt  (active_cnt),
        .health      (health),
        .event_valid (event_valid),
        .event_idx   (event_idx),
        .event_time  (event_time),
        .overflow    (overflow),
        .glitch      (glitch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [5:0]  act;
        logic        rr;
        logic        pop;
        logic [1:0]  hl;
        logic [2:0]  cnt;
        logic        rj;
        logic        vld;
        logic [2:0]  idx;
        logic [15:0] tm;
    } vec_t;

    vec_t vecs [17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_rearm(input logic [5:0] restore, input logic [1:0] exp_health);
        rearm_req = 1'b1;
        step();
        chk("rearm_pulse_hi", 32'(rearm_j), 32'd1);
        rearm_req = 1'b0;
        step();
        chk("rearm_pulse_lo", 32'(rearm_j), 32'd0);
        active_i = restore;
        step();
        step();
        chk("rearm_health", 32'(health), 32'(exp_health));
    endtask

    initial begin
        logic [2:0] drain_exp [8];
        //            act    rr    pop   hl    cnt   rj    vld   idx   time
        vecs[0]  = '{6'h00, 1'b0, 1'b0, 2'd0, 3'd0, 1'b1, 1'b0, 3'd0, 16'd0};
        vecs[1]  = '{6'h00, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0, 3'd0, 16'd0};
        vecs[2]  = '{6'h3F, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0, 3'd0, 16'd0};
        vecs[3]  = '{6'h3F, 1'b0, 1'b0, 2'd1, 3'd6, 1'b0, 1'b0, 3'd0, 16'd0};
        vecs[4]  = '{6'h3F, 1'b0, 1'b0, 2'd1, 3'd6, 1'b0, 1'b0, 3'd0, 16'd0};
        vecs[5]  = '{6'h37, 1'b0, 1'b0, 2'd1, 3'd6, 1'b0, 1'b0, 3'd0, 16'd0};
        vecs[6]  = '{6'h37, 1'b0, 1'b0, 2'd2, 3'd5, 1'b0, 1'b1, 3'd3, TS_ON ? 16'd6 : 16'd0};
        vecs[7]  = '{6'h37, 1'b0, 1'b1, 2'd2, 3'd5, 1'b0, 1'b0, 3'd0, 16'd0};
        vecs[8]  = '{6'h37, 1'b1, 1'b0, 2'd0, 3'd5, 1'b1, 1'b0, 3'd0, 16'd0};
        vecs[9]  = '{6'h37, 1'b0, 1'b0, 2'd0, 3'd5, 1'b0, 1'b0, 3'd0, 16'd0};
        vecs[10] = '{6'h3F, 1'b0, 1'b0, 2'd0, 3'd5, 1'b0, 1'b0, 3'd0, 16'd0};
        vecs[11] = '{6'h3F, 1'b0, 1'b0, 2'd1, 3'd6, 1'b0, 1'b0, 3'd0, 16'd0};
        vecs[12] = '{6'h1C, 1'b0, 1'b0, 2'd1, 3'd6, 1'b0, 1'b0, 3'd0, 16'd0};
        vecs[13] = '{6'h1C, 1'b0, 1'b0, 2'd3, 3'd3, 1'b0, 1'b1, 3'd0, TS_ON ? 16'd13 : 16'd0};
        vecs[14] = '{6'h1C, 1'b0, 1'b1, 2'd3, 3'd3, 1'b0, 1'b1, 3'd1, TS_ON ? 16'd14 : 16'd0};
        vecs[15] = '{6'h1C, 1'b0, 1'b1, 2'd3, 3'd3, 1'b0, 1'b1, 3'd5, TS_ON ? 16'd15 : 16'd0};
        vecs[16] = '{6'h1C, 1'b0, 1'b1, 2'd3, 3'd3, 1'b0, 1'b0, 3'd0, 16'd0};

        rst_n = 1'b0;
        active_i = 6'h00;
        sum_i = 1'b0;
        rearm_req = 1'b0;
        event_pop = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rearm_j", 32'(rearm_j), 32'd0);
        chk("rst_cnt", 32'(active_cnt), 32'd0);
        chk("rst_health", 32'(health), 32'd0);
        chk("rst_valid", 32'(event_valid), 32'd0);
        chk("rst_idx", 32'(event_idx), 32'd0);
        chk("rst_time", 32'(event_time), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_glitch", 32'(glitch), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            active_i  = vecs[i].act;
            rearm_req = vecs[i].rr;
            event_pop = vecs[i].pop;
            step();
            chk($sformatf("v%0d_health", i), 32'(health), 32'(vecs[i].hl));
            chk($sformatf("v%0d_cnt", i), 32'(active_cnt), 32'(vecs[i].cnt));
            chk($sformatf("v%0d_rearm_j", i), 32'(rearm_j), 32'(vecs[i].rj));
            chk($sformatf("v%0d_valid", i), 32'(event_valid), 32'(vecs[i].vld));
            if (vecs[i].vld) begin
                chk($sformatf("v%0d_idx", i), 32'(event_idx), 32'(vecs[i].idx));
                chk($sformatf("v%0d_time", i), 32'(event_time), 32'(vecs[i].tm));
            end
            chk($sformatf("v%0d_ovf", i), 32'(overflow), 32'd0);
            chk($sformatf("v%0d_glitch", i), 32'(glitch), 32'd0);
        end
        rearm_req = 1'b0;
        event_pop = 1'b0;

        // Fill: 3 events (2,3,4), re-arm, 5 more (0..4) -> exactly full.
        active_i = 6'h00;
        repeat (5) step();
        chk("fill_valid3", 32'(event_valid), 32'd1);
        do_rearm(6'h3F, 2'd1);
        active_i = 6'h20;
        repeat (7) step();
        chk("full_ovf0", 32'(overflow), 32'd0);
        chk("full_health", 32'(health), 32'd3);
        // Push of idx5 coinciding with a pop on the full FIFO.
        active_i = 6'h00;
        step();
        event_pop = 1'b1;
        step();
        event_pop = 1'b0;
        chk("pop_push_ovf", 32'(overflow), 32'd0);
        chk("pop_push_valid", 32'(event_valid), 32'd1);
        // One more push with no pop is dropped.
        do_rearm(6'h3F, 2'd1);
        active_i = 6'h3E;
        step();
        step();
        chk("drop_ovf", 32'(overflow), 32'd1);
        chk("drop_health", 32'(health), 32'd2);

        drain_exp = '{3'd3, 3'd4, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
        event_pop = 1'b1;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("drain%0d_valid", k), 32'(event_valid), 32'd1);
            chk($sformatf("drain%0d_idx", k), 32'(event_idx), 32'(drain_exp[k]));
            step();
        end
        event_pop = 1'b0;
        chk("drain_empty", 32'(event_valid), 32'd0);
        chk("drain_ovf_sticky", 32'(overflow), 32'd1);

        // Glitch: bit 2 drops then returns while DEGRADED.
        active_i = 6'h3A;
        repeat (3) step();
        chk("pre_glitch_health", 32'(health), 32'd2);
        chk("pre_glitch", 32'(glitch), 32'd0);
        active_i = 6'h3E;
        step();
        step();
        chk("glitch_set", 32'(glitch), 32'd1);
        chk("glitch_health", 32'(health), 32'd2);
        do_rearm(6'h3F, 2'd1);
        chk("glitch_sticky", 32'(glitch), 32'd1);
        chk("fifo_survives_rearm", 32'(event_valid), 32'd1);

        // Asynchronous reset while in SETTLE.
        rearm_req = 1'b1;
        step();
        rearm_req = 1'b0;
        step();
        chk("settle_health", 32'(health), 32'd0);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_rearm_j", 32'(rearm_j), 32'd0);
        chk("arst_cnt", 32'(active_cnt), 32'd0);
        chk("arst_health", 32'(health), 32'd0);
        chk("arst_valid", 32'(event_valid), 32'd0);
        chk("arst_idx", 32'(event_idx), 32'd0);
        chk("arst_time", 32'(event_time), 32'd0);
        chk("arst_ovf", 32'(overflow), 32'd0);
        chk("arst_glitch", 32'(glitch), 32'd0);
        active_i = 6'h00;
        step();
        rst_n = 1'b1;
        step();
        chk("restart_rearm_j", 32'(rearm_j), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
